// File: rtl/mdu_hilo_unit.sv
// E-stage multiply/divide unit owning HI/LO.
// Results are computed at start and committed after a fixed busy window.
module mdu_hilo_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  MDU_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_res
);

    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [4:0] OP_MULT  = 5'd1;
    localparam logic [4:0] OP_MULTU = 5'd2;
    localparam logic [4:0] OP_DIV   = 5'd3;
    localparam logic [4:0] OP_DIVU  = 5'd4;
    localparam logic [4:0] OP_MFHI  = 5'd5;
    localparam logic [4:0] OP_MFLO  = 5'd6;
    localparam logic [4:0] OP_MTHI  = 5'd7;
    localparam logic [4:0] OP_MTLO  = 5'd8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic        is_mul;
    logic        is_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] b_nz;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] bm_nz;
    logic [31:0] sq_mag;
    logic [31:0] sr_mag;
    logic [31:0] calc_hi;
    logic [31:0] calc_lo;

    assign is_mul = (MDU_op == OP_MULT) || (MDU_op == OP_MULTU);
    assign is_div = (MDU_op == OP_DIV)  || (MDU_op == OP_DIVU);

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divisor forced non-zero so the datapath never produces X; the
    // result of a divide by zero is discarded via pend_wr.
    assign b_nz   = (B == 32'd0) ? 32'd1 : B;
    assign a_mag  = A[31] ? (~A + 32'd1) : A;
    assign b_mag  = B[31] ? (~B + 32'd1) : B;
    assign bm_nz  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign sq_mag = a_mag / bm_nz;
    assign sr_mag = a_mag % bm_nz;

    always_comb begin
        calc_hi = 32'd0;
        calc_lo = 32'd0;
        case (MDU_op)
            OP_MULT: begin
                calc_hi = prod_s[63:32];
                calc_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                calc_hi = prod_u[63:32];
                calc_lo = prod_u[31:0];
            end
            OP_DIV: begin
                // Magnitude divide; 0x80000000/-1 falls out as 0x80000000 r 0
                calc_lo = (A[31] ^ B[31]) ? (~sq_mag + 32'd1) : sq_mag;
                calc_hi = A[31] ? (~sr_mag + 32'd1) : sr_mag;
            end
            OP_DIVU: begin
                calc_lo = A / b_nz;
                calc_hi = A % b_nz;
            end
            default: begin
                calc_hi = 32'd0;
                calc_lo = 32'd0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                if (start && (is_mul || is_div)) begin
                    pend_hi_d = calc_hi;
                    pend_lo_d = calc_lo;
                    pend_wr_d = !(is_div && (B == 32'd0));
                    cnt_d     = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end else if (!start && (MDU_op == OP_MTHI)) begin
                    hi_d = A;
                end else if (!start && (MDU_op == OP_MTLO)) begin
                    lo_d = A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        MDU_res = 32'd0;
        if (MDU_op == OP_MFHI) begin
            MDU_res = hi_q;
        end else if (MDU_op == OP_MFLO) begin
            MDU_res = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Directed bench for mdu_hilo_unit with an HI/LO result scoreboard.
// Expected pairs are queued at issue and compared when busy drops.
module tb_mdu_hilo_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  MDU_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_res;

    int tests;
    int fails;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];

    mdu_hilo_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .MDU_op (MDU_op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .MDU_res(MDU_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 none, 1 mtlo while busy, 2 start(div) while busy
    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] ehi,
                          input logic [31:0] elo, input int kind);
        exp_t e;
        int   cyc;
        e.hi = ehi;
        e.lo = elo;
        start  = 1'b1;
        MDU_op = op;
        A      = a;
        B      = b;
        sb.push_back(e);
        tick();
        start  = 1'b0;
        MDU_op = 5'd0;
        A      = 32'h0;
        B      = 32'h0;
        cyc    = 0;
        while (busy === 1'b1 && cyc < n + 5) begin
            cyc++;
            if (cyc == 2 && kind == 1) begin
                MDU_op = 5'd8;
                A      = 32'hCAFEF00D;
            end else if (cyc == 2 && kind == 2) begin
                start  = 1'b1;
                MDU_op = 5'd3;
                A      = 32'd100;
                B      = 32'd7;
            end else begin
                start  = 1'b0;
                MDU_op = 5'd0;
                A      = 32'h0;
                B      = 32'h0;
            end
            tick();
        end
        start  = 1'b0;
        MDU_op = 5'd0;
        chk({tag, "_busy_cycles"}, 32'(cyc), 32'(n));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_hi"}, HI, e.hi);
            chk({tag, "_lo"}, LO, e.lo);
        end
    endtask

    initial begin
        logic [31:0]     ra;
        logic [31:0]     rb;
        longint          sp;
        longint unsigned up;
        tests  = 0;
        fails  = 0;
        reset  = 1'b0;
        start  = 1'b0;
        MDU_op = 5'd0;
        A      = 32'h0;
        B      = 32'h0;
        tick();
        tick();
        reset  = 1'b1;
        MDU_op = 5'd5;
        tick();
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_mfhi", MDU_res, 32'h0);
        MDU_op = 5'd0;

        run_op("mult", 5'd1, 32'hFFFFFFFF, 32'd2, 5,
               32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op("multu", 5'd2, 32'hFFFFFFFF, 32'd2, 5,
               32'h00000001, 32'hFFFFFFFE, 0);
        run_op("div", 5'd3, 32'hFFFFFFF9, 32'd2, 10,
               32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("divu", 5'd4, 32'hFFFFFFF9, 32'd2, 10,
               32'h00000001, 32'h7FFFFFFC, 0);

        MDU_op = 5'd7;
        A      = 32'h11;
        tick();
        MDU_op = 5'd8;
        A      = 32'h22;
        tick();
        MDU_op = 5'd0;
        run_op("div0", 5'd3, 32'h1234, 32'h0, 10, 32'h11, 32'h22, 0);
        run_op("ovf", 5'd3, 32'h80000000, 32'hFFFFFFFF, 10,
               32'h0, 32'h80000000, 0);

        MDU_op = 5'd7;
        A      = 32'hDEADBEEF;
        tick();
        MDU_op = 5'd0;
        chk("mthi_hi", HI, 32'hDEADBEEF);
        chk("mthi_busy", {31'b0, busy}, 32'h0);

        run_op("mult_mtlo", 5'd1, 32'd3, 32'hFFFFFFFE, 5,
               32'hFFFFFFFF, 32'hFFFFFFFA, 1);
        MDU_op = 5'd6;
        #1;
        chk("mflo", MDU_res, 32'hFFFFFFFA);
        MDU_op = 5'd5;
        #1;
        chk("mfhi", MDU_res, 32'hFFFFFFFF);
        MDU_op = 5'd0;
        #1;
        chk("mf_none", MDU_res, 32'h0);

        run_op("multu_restart", 5'd2, 32'h10000, 32'h10000, 5,
               32'h1, 32'h0, 2);

        // start with a non-arith op is ignored
        start  = 1'b1;
        MDU_op = 5'd7;
        A      = 32'h55;
        tick();
        start  = 1'b0;
        MDU_op = 5'd0;
        chk("bad_start_busy", {31'b0, busy}, 32'h0);
        chk("bad_start_hi", HI, 32'h1);

        ra = $urandom;
        rb = $urandom;
        sp = longint'(signed'(ra)) * longint'(signed'(rb));
        run_op("mult_rand", 5'd1, ra, rb, 5, sp[63:32], sp[31:0], 0);
        ra = $urandom;
        rb = $urandom;
        up = {32'd0, ra} * {32'd0, rb};
        run_op("multu_rand", 5'd2, ra, rb, 5, up[63:32], up[31:0], 0);

        start  = 1'b1;
        MDU_op = 5'd1;
        A      = 32'd9;
        B      = 32'd9;
        tick();
        start  = 1'b0;
        MDU_op = 5'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_hi", HI, 32'h0);
        chk("midrst_lo", LO, 32'h0);
        reset = 1'b1;
        repeat (8) tick();
        chk("midrst_late_hi", HI, 32'h0);
        chk("midrst_late_lo", LO, 32'h0);
        chk("midrst_late_busy", {31'b0, busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
